vl_dline_arb: RTL and testbench
===============================

# vl_dline_arb

Round-robin arbiter and sequencer for a shared fixed-latency delay line. Up to NREQ requesters compete for one WIDTH-bit pipeline of DEPTH stages. Each accepted word carries a valid bit and a requester ID tag, and returns on a single tagged output port exactly DEPTH cycles later. A flush handshake drains in-flight traffic, then clears the pipeline, so the datapath can be reset without losing accepted words.

## Interface
- NREQ, 4: number of requesters (2..16)
- DEPTH, 8: pipeline stages (>=1)
- WIDTH, 8: data width
- IDW, 2: tag width, >= clog2(NREQ)

- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- req  input  NREQ  per-requester request level; must hold until granted
- req_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant (combinational); accept = req[i] & gnt[i]
- flush_req  input  1  level request to drain and clear
- flush_ack  output  1  one-cycle pulse: pipeline empty and cleared
- busy  output  1  high when in-flight count != 0 or FSM != RUN
- out_vld  output  1  returned word valid
- out_id  output  IDW  requester index of returned word
- out_data  output  WIDTH  returned data

## Operation
- **Arbitration**
  - Round-robin pointer ptr (0..NREQ-1), reset 0.
  - The grant goes to the first asserted req searching ptr, ptr+1, … with wrap-around.
  - On any grant to index k, ptr <= (k+1) mod NREQ. With no grant, ptr holds.
  - At most one gnt bit is high. gnt = 0 whenever FSM != RUN.
- **Pipeline**
  - Per stage: vld, id[IDW], data[WIDTH].
  - On accept, stage 0 loads {1, k, req_data[k]}. Otherwise stage 0 loads {0, 0, 0}.
  - Stage s loads stage s-1 every cycle; there is no stall.
  - Outputs are driven from stage DEPTH-1.
- **In-flight counter**
  - Range 0..DEPTH (0..DEPTH+1 with the output register), reset 0.
  - +1 on accept, -1 on out_vld. Both in the same cycle: unchanged.
- **FSM** (reset state RUN)
  - RUN: arbitrate normally. flush_req=1 -> DRAIN; no grant is issued in that same cycle.
  - DRAIN: no grants; wait until count==0 -> CLEAR.
  - CLEAR: one cycle. All stage vld/id/data go to 0, flush_ack=1, ptr reset to 0. -> HOLD.
  - HOLD: wait for flush_req==0 -> RUN. Further flush_req activity is ignored until RUN.
- **Reset values**
  - gnt=0, flush_ack=0, busy=0, out_vld=0, out_id=0, out_data=0.
  - All stages 0, count 0, ptr 0.
- **Boundary conditions**
  - Reset mid-flush or mid-traffic discards everything immediately; no ack is issued.
  - A requester that drops req before being granted is simply skipped. Protocol violation is not flagged.
  - flush_req asserted while count==0 still passes through DRAIN for one cycle (RUN->DRAIN->CLEAR).

## Timing
- An accept in cycle t gives out_vld=1 in cycle t+DEPTH, with the matching out_id and out_data.
- Throughput is one accept per cycle. Back-to-back accepts from different requesters return back-to-back in grant order.
- flush_ack asserts in cycle (last out_vld)+2 at the earliest: the DRAIN exit is registered, then CLEAR.
- busy is registered from count and FSM state, one cycle behind.

## Configuration
- Macro: `VL_DLINE_ARB_OUT_REG_EN`.
- **Defined:**
  - An extra output register stage follows stage DEPTH-1, so latency = DEPTH+1.
  - The counter range extends to DEPTH+1.
  - CLEAR also zeros the output register.
- **Undefined:** outputs are driven directly from stage DEPTH-1, latency = DEPTH.

## Test plan
- **Reset.** Reset held, then released with all req=0 -> all outputs 0 and busy=0 for 20 cycles.
- **Single requester.** req=4'b0100 held, req_data[2]=8'hA5 (DEPTH=8) -> gnt=4'b0100 every cycle; first out_vld at accept+8 with out_id=2, out_data=8'hA5.
- **Fairness.** All four req held for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; returned out_id in the same order, 8 cycles later.
- **Wrap with sparse requests.** Last grant to 3, then req=4'b1001 -> grant to 0, then 3, then 0.
- **Flush mid-traffic.** Five words in flight, then flush_req=1 -> gnt=0 from that cycle; all 5 words emerge intact; flush_ack is a single pulse after count reaches 0; no new gnt until flush_req drops.
- **Reset mid-flush.** reset_n pulsed during DRAIN -> out_vld=0 immediately, no flush_ack, FSM=RUN, ptr=0 after release.

Source files
------------

// File: rtl/vl_dline_arb.sv
// vl_dline_arb
// Round-robin arbiter feeding a shared fixed-latency delay line. Each accepted
// word travels with its valid bit and requester tag. It reappears on the
// tagged output port a fixed number of cycles after it was accepted. A flush
// handshake stops new grants and waits until in-flight words have drained.
// It then clears the pipeline, pulses flush_ack, and waits for flush_req to
// drop before arbitration resumes.
//
// Parameters: NREQ requesters, DEPTH stages, WIDTH data bits, IDW tag bits.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   req, req_data  per-requester request level and data (lane i at i*WIDTH)
//   gnt            combinational one-hot grant; accept = req[i] & gnt[i]
//   flush_req      level request to drain and clear the pipeline
//   flush_ack      one-cycle pulse once the pipeline is empty and cleared
//   busy           registered: words in flight or flush sequence active
//   out_vld/out_id/out_data  returned word from the end of the delay line
//
// Configuration macro: VL_DLINE_ARB_OUT_REG_EN adds an output register after
// the last stage. The latency then becomes DEPTH+1.
module vl_dline_arb #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    input  logic                  flush_req,
    output logic                  flush_ack,
    output logic                  busy,
    output logic                  out_vld,
    output logic [IDW-1:0]        out_id,
    output logic [WIDTH-1:0]      out_data
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(DEPTH + 2);

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR, HOLD} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt, scan_idx;
    logic [CW-1:0]     count;
    logic              accept;
    logic [IDW-1:0]    gnt_id;
    logic [WIDTH-1:0]  gnt_data;

    logic              stg_vld  [DEPTH];
    logic [IDW-1:0]    stg_id   [DEPTH];
    logic [WIDTH-1:0]  stg_data [DEPTH];

    // Round-robin search starting at ptr. Grants are blocked outside RUN,
    // on the cycle flush_req is seen, and while reset is held.
    always_comb begin
        gnt      = '0;
        accept   = 1'b0;
        gnt_id   = '0;
        gnt_data = '0;
        ptr_nxt  = ptr;
        scan_idx = '0;
        if (reset_n && state == RUN && !flush_req) begin
            for (int i = 0; i < NREQ; i++) begin
                scan_idx = PW'((int'(ptr) + i) % NREQ);
                if (!accept && req[scan_idx]) begin
                    accept        = 1'b1;
                    gnt[scan_idx] = 1'b1;
                    gnt_id        = IDW'(scan_idx);
                    gnt_data      = req_data[int'(scan_idx)*WIDTH +: WIDTH];
                    ptr_nxt       = (scan_idx == PW'(NREQ - 1)) ? '0 : scan_idx + PW'(1);
                end
            end
        end
    end

    // Pointer moves past the last granted index. It returns to 0 when the
    // flush clears the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (state == CLEAR)
            ptr <= '0;
        else if (accept)
            ptr <= ptr_nxt;
    end

    // Delay line with no stall. Stage 0 loads an empty bubble when there is
    // no accept, so idle slots carry zero tag and data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || state == CLEAR) begin
            for (int s = 0; s < DEPTH; s++) begin
                stg_vld[s]  <= 1'b0;
                stg_id[s]   <= '0;
                stg_data[s] <= '0;
            end
        end else begin
            stg_vld[0]  <= accept;
            stg_id[0]   <= gnt_id;
            stg_data[0] <= gnt_data;
            for (int s = 1; s < DEPTH; s++) begin
                stg_vld[s]  <= stg_vld[s-1];
                stg_id[s]   <= stg_id[s-1];
                stg_data[s] <= stg_data[s-1];
            end
        end
    end

`ifdef VL_DLINE_ARB_OUT_REG_EN
    // Optional retiming register after the last stage. CLEAR also empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld  <= 1'b0;
            out_id   <= '0;
            out_data <= '0;
        end else if (state == CLEAR) begin
            out_vld  <= 1'b0;
            out_id   <= '0;
            out_data <= '0;
        end else begin
            out_vld  <= stg_vld[DEPTH-1];
            out_id   <= stg_id[DEPTH-1];
            out_data <= stg_data[DEPTH-1];
        end
    end
`else
    assign out_vld  = stg_vld[DEPTH-1];
    assign out_id   = stg_id[DEPTH-1];
    assign out_data = stg_data[DEPTH-1];
`endif

    // In-flight count covers every accepted word that has not yet appeared
    // on the output port, including the output register if it is present.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else begin
            case ({accept, out_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // A flush always visits DRAIN, even when nothing is in flight. HOLD
    // ignores flush_req until it drops, so one request yields one ack.
    always_comb begin
        state_nxt = state;
        flush_ack = 1'b0;
        case (state)
            RUN:     if (flush_req) state_nxt = DRAIN;
            DRAIN:   if (count == '0) state_nxt = CLEAR;
            CLEAR: begin
                flush_ack = 1'b1;
                state_nxt = HOLD;
            end
            HOLD:    if (!flush_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            busy <= 1'b0;
        else
            busy <= (count != '0) || (state != RUN);
    end

endmodule

// File: tb/tb_vl_dline_arb.sv
// tb_vl_dline_arb
// Drives vl_dline_arb with directed and randomized request traffic.
// Compares every cycle against a reference model of the arbiter and delay
// line. The model keeps a queue of words with their due cycles, a round-robin
// pointer, and the flush acknowledge cycle worked out arithmetically.
`timescale 1ns/1ps
module tb_vl_dline_arb;
    localparam int NREQ  = 4;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
`ifdef VL_DLINE_ARB_OUT_REG_EN
    localparam int LAT = DEPTH + 1;
`else
    localparam int LAT = DEPTH;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       gnt;
    logic                  flush_req = 1'b0;
    logic                  flush_ack;
    logic                  busy;
    logic                  out_vld;
    logic [IDW-1:0]        out_id;
    logic [WIDTH-1:0]      out_data;

    always #5 clk = ~clk;

    vl_dline_arb #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt),
        .flush_req(flush_req), .flush_ack(flush_ack), .busy(busy),
        .out_vld(out_vld), .out_id(out_id), .out_data(out_data)
    );

    typedef struct {
        int due;
        int id;
        int data;
    } word_t;

    word_t inflight[$];
    int    ptr_m;
    int    cyc;
    int    ack_cycle;
    bit    flushing;
    bit    holding;
    bit    busy_m;
    bit    pin_lane2;
    int    errors = 0;
    int    checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_out_vld"}, 32'(out_vld), 32'd0);
        checkOutput({tag, "_out_id"}, 32'(out_id), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "_flush_ack"}, 32'(flush_ack), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic modelReset();
        inflight.delete();
        ptr_m    = 0;
        flushing = 1'b0;
        holding  = 1'b0;
        busy_m   = 1'b0;
    endtask

    task automatic runCycle();
        logic [NREQ-1:0] gnt_m;
        int    k;
        int    last_due;
        bit    run_now;
        bit    due_now;
        word_t w;
        @(negedge clk);
        run_now = !flushing && !holding;
        gnt_m   = '0;
        k       = -1;
        if (run_now && !flush_req) begin
            for (int i = 0; i < NREQ; i++) begin
                int j = (ptr_m + i) % NREQ;
                if (k < 0 && req[j]) k = j;
            end
        end
        if (k >= 0) gnt_m[k] = 1'b1;
        due_now = (inflight.size() > 0) && (inflight[0].due == cyc);
        checkOutput("gnt", 32'(gnt), 32'(gnt_m));
        checkOutput("out_vld", 32'(out_vld), 32'(due_now));
        checkOutput("out_id", 32'(out_id), due_now ? inflight[0].id : 0);
        checkOutput("out_data", 32'(out_data), due_now ? inflight[0].data : 0);
        checkOutput("flush_ack", 32'(flush_ack), 32'(flushing && cyc == ack_cycle));
        checkOutput("busy", 32'(busy), 32'(busy_m));

        busy_m = (inflight.size() != 0) || !run_now;
        if (due_now) void'(inflight.pop_front());
        if (k >= 0) begin
            w.due  = cyc + LAT;
            w.id   = k;
            w.data = int'(req_data[k*WIDTH +: WIDTH]);
            inflight.push_back(w);
            ptr_m = (k + 1) % NREQ;
        end
        if (run_now && flush_req) begin
            flushing  = 1'b1;
            last_due  = (inflight.size() > 0) ? inflight[$].due : 0;
            ack_cycle = (last_due + 2 > cyc + 2) ? last_due + 2 : cyc + 2;
        end else if (flushing && cyc == ack_cycle) begin
            flushing = 1'b0;
            holding  = 1'b1;
            ptr_m    = 0;
        end else if (holding && !flush_req) begin
            holding = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic f, input int n, input bit rnd);
        for (int c = 0; c < n; c++) begin
            req       = rnd ? NREQ'($urandom) : r;
            flush_req = f;
            req_data  = $urandom;
            if (pin_lane2) req_data[2*WIDTH +: WIDTH] = 8'hA5;
            runCycle();
        end
    endtask

    initial begin
        cyc       = 0;
        ack_cycle = 0;
        pin_lane2 = 1'b0;
        modelReset();

        // Reset held: every output quiet
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset_hold");
        reset_n = 1'b1;
        applyStimulus(4'b0000, 1'b0, 20, 1'b0);

        // Single requester with fixed data on lane 2
        pin_lane2 = 1'b1;
        applyStimulus(4'b0100, 1'b0, 12, 1'b0);
        applyStimulus(4'b0000, 1'b0, LAT + 2, 1'b0);
        pin_lane2 = 1'b0;

        // Fairness: put the pointer at 0, then all requesters for 8 cycles
        applyStimulus(4'b1000, 1'b0, 1, 1'b0);
        applyStimulus(4'b1111, 1'b0, 8, 1'b0);
        applyStimulus(4'b0000, 1'b0, LAT + 2, 1'b0);

        // Wrap with sparse requests
        applyStimulus(4'b1000, 1'b0, 1, 1'b0);
        applyStimulus(4'b1001, 1'b0, 3, 1'b0);
        applyStimulus(4'b0000, 1'b0, LAT + 2, 1'b0);

        // Random request traffic
        applyStimulus(4'b0000, 1'b0, 200, 1'b1);
        applyStimulus(4'b0000, 1'b0, LAT + 2, 1'b0);

        // Flush with five words in flight; requests stay high throughout
        applyStimulus(4'b1111, 1'b0, 5, 1'b0);
        applyStimulus(4'b1111, 1'b1, LAT + 8, 1'b0);
        applyStimulus(4'b1111, 1'b0, 3, 1'b0);
        applyStimulus(4'b0000, 1'b0, LAT + 2, 1'b0);

        // Flush on an empty pipeline; flush_req wiggles during HOLD
        applyStimulus(4'b0000, 1'b1, 1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1, 1'b0);
        applyStimulus(4'b0110, 1'b1, 2, 1'b0);
        applyStimulus(4'b0110, 1'b0, 4, 1'b0);
        applyStimulus(4'b0000, 1'b0, LAT + 2, 1'b0);

        // Reset asserted while draining
        applyStimulus(4'b1111, 1'b0, 3, 1'b0);
        applyStimulus(4'b1111, 1'b1, 3, 1'b0);
        reset_n = 1'b0;
        #1;
        checkIdle("reset_mid_flush");
        @(posedge clk);
        #1;
        checkIdle("reset_mid_flush_edge");
        reset_n   = 1'b1;
        flush_req = 1'b0;
        modelReset();
        applyStimulus(4'b1111, 1'b0, 6, 1'b0);
        applyStimulus(4'b0000, 1'b0, LAT + 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
